dl11_tx: RTL and testbench
==========================

# dl11_tx

DL11-style console transmitter for the vm1 CPU bus. It decodes the transmitter status register XCSR (177564) and the transmitter buffer XBUF (177566), and answers DIN/DOUT with RPLY. Each byte written to XBUF is serialised as 8N1 on `txd`. It raises VIRQ and supplies the interrupt vector on IAKO, replacing the behavioural console model in front of the CPU.

## Interface
- `CLKDIV`, default 16: `clk` cycles per serial bit; legal range 2..65535.
- `BASE`, default 'o177564: XCSR address. XBUF is at BASE+2.
- `VECTOR`, default 'o64: interrupt vector returned on acknowledge.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `ce`  in  1  CPU clock enable. Used only to qualify bus strobes.
- `addr_i`  in  16  CPU address (`addr_o` of vm1).
- `data_i`  in  16  CPU write data.
- `data_o`  out  16  read data. Zero when the block is not replying, so it can be OR-ed onto the bus.
- `SYNC`, `DIN`, `DOUT`, `WTBT`  in  1 each  vm1 bus strobes.
- `INIT`  in  1  bus init from the CPU; acts as a synchronous soft reset.
- `RPLY`  out  1  reply.
- `IAKO`  in  1  interrupt acknowledge from the CPU.
- `VIRQ`  out  1  interrupt request.
- `txd`  out  1  serial output, idle high.

## Operation
- Address select: `sel = SYNC & (addr_i[15:1] == BASE[15:1] or addr_i[15:1] == (BASE+2)[15:1])`.
- Bus cycle:
  - When `ce & sel & (DIN|DOUT)`, RPLY goes high on the next `clk` edge.
  - RPLY stays high until SYNC drops, then clears on the next edge.
  - Each DOUT write takes effect exactly once, on the edge that raises RPLY.
- XCSR read data:
  - `{8'o0, READY, IE, 6'o0}`.
  - Bit 7 is READY, bit 6 is IE.
- XBUF read data: 0.
- XCSR write: only IE (`data_i[6]`) is stored. A byte write to odd address BASE+1 is ignored.
- XBUF write (word, or byte at the even address):
  - If READY=1: load `data_i[7:0]` into the shift register, clear READY, start a frame.
  - If READY=0: the write is dropped, but RPLY is still given.
- Transmit FSM:
  - States IDLE → START → DATA(bit 0..7, LSB first) → STOP → IDLE.
  - Each bit lasts CLKDIV clocks, timed by a 16-bit down-counter.
  - `txd` is 0 in START, the data bit in DATA, and 1 in STOP and IDLE.
  - On leaving STOP, READY is set.
- Interrupt request flop `irq`:
  - Set on a rising edge of `IE & READY`. This includes writing IE=1 while READY=1.
  - Cleared when IE is written to 0, on vector acknowledge, or on INIT.
  - `VIRQ = irq`.
- Vector acknowledge: `ce & IAKO & DIN & irq` gives RPLY with `data_o = VECTOR`. `irq` clears on the edge that raises RPLY.
- IAKO while `irq=0`: no RPLY, `data_o=0`, so a daisy-chained device can answer.
- INIT, synchronous, held for its whole duration:
  - Abort any frame, FSM to IDLE.
  - `txd=1`, READY=1, IE=0, `irq=0`.
  - RPLY is still generated for cycles in progress.
- Simultaneous events:
  - A frame completing on the same edge as an XCSR write of IE=1: `irq` sets exactly once.
  - Acknowledge and a new READY rising edge on the same edge: set wins.

## Timing
- Reset values: `RPLY=0`, `VIRQ=0`, `data_o=0`, `txd=1`, READY=1, IE=0, FSM IDLE.
- Reset asserted mid-frame aborts it immediately.
- Reply latency: 1 `clk` after the first qualifying `ce` edge.
- `data_o` is valid from the RPLY-rising edge while RPLY=1. It is registered, not combinational from `addr_i`.
- Frame timing:
  - The start bit begins on the edge after the XBUF-write RPLY edge.
  - READY rises exactly 10×CLKDIV clocks after the start bit begins.
  - With IE=1, VIRQ rises on the same edge as READY.
- `data_o` returns to 0 on the edge RPLY falls.

## Test plan
- Reset, then read XCSR with CLKDIV=4 → RPLY one clk after `ce&SYNC&DIN`, `data_o` = 'o200, `txd`=1, VIRQ=0.
- Word write XBUF='o101 ('A') → READY reads 0. `txd` shows 0, then bits 1,0,0,0,0,0,1,0 (LSB first), then 1, each 4 clocks. READY=1 exactly 40 clocks after the start bit.
- Write XCSR='o100 while idle → VIRQ=1 next edge. IAKO+DIN → RPLY with `data_o`='o64, VIRQ=0. A following IAKO gets no RPLY.
- With IE=1, write XBUF, then immediately write XBUF='o102 while busy → the second byte is dropped, only 'A' appears on `txd`. VIRQ rises at frame end.
- Assert INIT mid-frame (bit 3) → `txd`=1 next edge, XCSR reads 'o200, VIRQ=0. The next XBUF write starts a clean frame.
- Byte write 'o377 to 'o177565 → RPLY given, XCSR unchanged ('o200). Address 'o177562 → no RPLY, `data_o`=0.

Source files
------------

// File: rtl/dl11_tx.sv
// dl11_tx: DL11-style console transmitter (XCSR/XBUF) on the vm1 bus, 8N1 serial out with vectored interrupt.
module dl11_tx #(
  parameter int          CLKDIV = 16,
  parameter logic [15:0] BASE   = 16'o177564,
  parameter logic [15:0] VECTOR = 16'o64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  input  logic        SYNC,
  input  logic        DIN,
  input  logic        DOUT,
  input  logic        WTBT,
  input  logic        INIT,
  output logic        RPLY,
  input  logic        IAKO,
  output logic        VIRQ,
  output logic        txd
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] XBUF   = BASE + 16'd2;
  localparam logic [15:0] DIV_M1 = 16'(CLKDIV - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, data_q, data_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_q, bit_d;
  logic        rply_q, rply_d, rdy_q, rdy_d, ie_q, ie_d, irq_q, irq_d, txd_q, txd_d;
  logic        is_csr, sel, ack, bus, wr_ok, csr_wr, buf_wr, tick, set_irq;
  logic        unused_hi;
  assign unused_hi = ^data_i[15:8];
  always_comb begin
    is_csr  = addr_i[15:1] == BASE[15:1];
    sel     = SYNC & (is_csr | addr_i[15:1] == XBUF[15:1]);
    ack     = ce & IAKO & DIN & irq_q & !rply_q;
    bus     = ce & sel & (DIN | DOUT) & !rply_q & !ack;
    wr_ok   = bus & DOUT & !(WTBT & addr_i[0]) & !INIT;
    csr_wr  = wr_ok & is_csr;
    buf_wr  = wr_ok & !is_csr & rdy_q;
    tick    = cnt_q == 16'd0;
    rply_d  = ack | bus | (rply_q & (SYNC | (IAKO & DIN)));
    data_d  = ack ? VECTOR :
              bus ? ((DIN & is_csr) ? {8'o0, rdy_q, ie_q, 6'o0} : 16'o0) :
              rply_d ? data_q : 16'o0;
    state_d = state_q;
    cnt_d   = tick ? DIV_M1 : cnt_q - 16'd1;
    sh_d    = sh_q;
    bit_d   = bit_q;
    rdy_d   = rdy_q;
    // READY low while IDLE means a byte is waiting: launch the start bit next edge.
    case (state_q)
      IDLE: begin
        cnt_d = DIV_M1;
        if (!rdy_q) state_d = START;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (tick) begin
        sh_d  = sh_q >> 1;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (tick) begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (buf_wr) begin
      sh_d  = data_i[7:0];
      rdy_d = 1'b0;
    end
    ie_d = csr_wr ? data_i[6] : ie_q;
    if (INIT) begin
      state_d = IDLE;
      cnt_d   = DIV_M1;
      rdy_d   = 1'b1;
      ie_d    = 1'b0;
    end
    set_irq = ie_d & rdy_d & !(ie_q & rdy_q);
    irq_d   = set_irq | (irq_q & !ack & !(csr_wr & !data_i[6]) & !INIT);
    txd_d   = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= DIV_M1;
      sh_q    <= 8'd0;
      bit_q   <= 3'd0;
      rply_q  <= 1'b0;
      data_q  <= 16'o0;
      rdy_q   <= 1'b1;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      rply_q  <= rply_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ie_q    <= ie_d;
      irq_q   <= irq_d;
      txd_q   <= txd_d;
    end
  end
  assign RPLY   = rply_q;
  assign data_o = data_q;
  assign VIRQ   = irq_q;
  assign txd    = txd_q;
endmodule

// File: tb/tb_dl11_tx.sv
// tb_dl11_tx: randomized scoreboard bench for dl11_tx against a cycle-arithmetic reference model.
module tb_dl11_tx;
  localparam int          C    = 4;
  localparam logic [15:0] CSR  = 16'o177564;
  localparam logic [15:0] XBUF = 16'o177566;
  localparam logic [15:0] VEC  = 16'o64;
  logic clk = 0, reset = 1, ce = 0, SYNC = 0, DIN = 0, DOUT = 0, WTBT = 0, INIT = 0, IAKO = 0;
  logic [15:0] addr_i = 0, data_i = 0, data_o;
  logic RPLY, VIRQ, txd;
  always #5 clk = ~clk;
  dl11_tx #(.CLKDIV(C), .BASE(CSR), .VECTOR(VEC)) dut (
    .clk(clk), .reset(reset), .ce(ce), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT), .WTBT(WTBT), .INIT(INIT), .RPLY(RPLY),
    .IAKO(IAKO), .VIRQ(VIRQ), .txd(txd));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, passes = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (o%0o) expected %0d (o%0o) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask
  // Reference model: READY is high after edge n iff n >= rdy_edge; one frame at a time.
  int rdy_edge = 0;
  bit m_ie = 0;
  int f_start = -100000, f_end = -100000;
  logic [7:0] f_byte = 0;
  function automatic bit rdy_after(input int n);
    return n >= rdy_edge;
  endfunction
  function automatic logic exp_txd(input int n);
    int k;
    if (n < f_start || n >= f_end) return 1'b1;
    k = (n - f_start) / C;
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : f_byte[k-1];
  endfunction
  typedef struct {int at; int data; bit chk_data;} rsp_t;
  rsp_t sbq[$];
  bit rply_prev = 0;
  always @(posedge clk) begin
    rsp_t r;
    #1;
    if (RPLY && !rply_prev) begin
      if (sbq.size() == 0) chk("unexpected_rply", 1, 0);
      else begin
        r = sbq.pop_front();
        chk("rply_edge", cyc, r.at);
        if (r.chk_data) chk("rply_data", data_o, r.data);
      end
    end
    rply_prev = RPLY;
  end
  always @(posedge clk) begin
    #2;
    if (!reset) chk("txd", txd, exp_txd(cyc));
  end
  task automatic bus(input logic [15:0] a, input bit wr, input bit bt, input logic [15:0] d, input int ce_dly);
    int n0;
    bit csr;
    rsp_t r;
    @(negedge clk);
    addr_i = a; data_i = d; WTBT = bt; SYNC = 1; DIN = !wr; DOUT = wr; ce = (ce_dly == 0);
    repeat (ce_dly) @(negedge clk);
    ce = 1;
    n0 = cyc + 1;
    csr = a[15:1] == CSR[15:1];
    r.at = n0;
    r.chk_data = !wr;
    r.data = (!wr && csr) ? ((rdy_after(n0 - 1) ? 128 : 0) | (m_ie ? 64 : 0)) : 0;
    sbq.push_back(r);
    if (wr && !(bt && a[0])) begin
      if (csr) m_ie = d[6];
      else if (rdy_after(n0 - 1)) begin
        rdy_edge = n0 + 1 + 10 * C;
        f_start = n0 + 1;
        f_end = rdy_edge;
        f_byte = d[7:0];
      end
    end
    for (int i = 0; i < 8 && !RPLY; i++) @(negedge clk);
    chk("rply_seen", RPLY, 1);
    SYNC = 0; DIN = 0; DOUT = 0; WTBT = 0;
    for (int i = 0; i < 8 && RPLY; i++) @(negedge clk);
    chk("rply_clear", RPLY, 0);
    chk("data_idle", data_o, 0);
  endtask
  task automatic iak(input bit expect_reply);
    rsp_t r;
    @(negedge clk);
    addr_i = 0; IAKO = 1; DIN = 1; ce = 1;
    if (expect_reply) begin
      r.at = cyc + 1; r.data = VEC; r.chk_data = 1;
      sbq.push_back(r);
      for (int i = 0; i < 8 && !RPLY; i++) @(negedge clk);
      chk("iak_rply", RPLY, 1);
      IAKO = 0; DIN = 0;
      for (int i = 0; i < 8 && RPLY; i++) @(negedge clk);
      chk("iak_rply_clear", RPLY, 0);
      chk("iak_virq_clear", VIRQ, 0);
    end else begin
      repeat (3) begin
        @(negedge clk);
        chk("iak_no_rply", RPLY, 0);
        chk("iak_no_data", data_o, 0);
      end
      IAKO = 0; DIN = 0;
    end
  endtask
  task automatic noreply(input logic [15:0] a);
    @(negedge clk);
    addr_i = a; SYNC = 1; DIN = 1; ce = 1;
    repeat (3) begin
      @(negedge clk);
      chk("foreign_no_rply", RPLY, 0);
      chk("foreign_no_data", data_o, 0);
    end
    SYNC = 0; DIN = 0;
  endtask
  task automatic do_init();
    int a;
    @(negedge clk);
    a = cyc + 1;
    INIT = 1;
    if (f_end > a) f_end = a;
    rdy_edge = a;
    m_ie = 0;
    repeat (2) @(negedge clk);
    INIT = 0;
  endtask
  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic check_virq_at_ready();
    int r;
    r = rdy_edge;
    wait_until(r - 1);
    chk("virq_before_ready", VIRQ, 0);
    @(negedge clk);
    chk("virq_with_ready", VIRQ, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end
  initial begin
    int op;
    logic [15:0] a;
    repeat (3) @(negedge clk);
    chk("reset_rply", RPLY, 0);
    chk("reset_virq", VIRQ, 0);
    chk("reset_data", data_o, 0);
    chk("reset_txd", txd, 1);
    reset = 0;
    ce = 1;
    bus(CSR, 0, 0, 0, 0);
    bus(CSR, 0, 0, 0, 2);
    bus(XBUF, 1, 0, 16'o101, 0);
    bus(CSR, 0, 0, 0, 0);
    wait_until(rdy_edge - 2);
    bus(CSR, 0, 0, 0, 0);
    bus(CSR, 0, 0, 0, 0);
    chk("virq_ie0", VIRQ, 0);
    bus(CSR, 1, 0, 16'o100, 0);
    chk("virq_ie_write", VIRQ, 1);
    iak(1);
    iak(0);
    bus(XBUF, 1, 0, 16'o101, 0);
    bus(XBUF, 1, 0, 16'o102, 0);
    chk("virq_busy", VIRQ, 0);
    check_virq_at_ready();
    bus(CSR, 1, 0, 16'o0, 0);
    chk("virq_ie_clear", VIRQ, 0);
    bus(CSR, 1, 0, 16'o100, 0);
    iak(1);
    bus(XBUF, 1, 0, 16'($urandom_range(0, 255)), 0);
    wait_until(f_start + 4 * C + 1);
    do_init();
    chk("virq_after_init", VIRQ, 0);
    bus(CSR, 0, 0, 0, 0);
    bus(XBUF, 1, 0, 16'($urandom_range(0, 255)), 0);
    wait_until(rdy_edge + 1);
    bus(CSR + 16'd1, 1, 1, 16'o377, 0);
    bus(CSR, 0, 0, 0, 0);
    chk("virq_odd_byte", VIRQ, 0);
    noreply(16'o177562);
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: bus(CSR, 0, 0, 0, $urandom_range(0, 2));
        1: bus(XBUF, 0, 0, 0, $urandom_range(0, 2));
        2: begin
          a = ($urandom_range(0, 1) != 0) ? XBUF : XBUF + 16'd1;
          bus(a, 1, $urandom_range(0, 1) != 0, 16'($urandom), $urandom_range(0, 2));
        end
        3: begin
          a = ($urandom_range(0, 1) != 0) ? CSR : CSR + 16'd1;
          bus(a, 1, $urandom_range(0, 1) != 0, 16'($urandom), $urandom_range(0, 2));
        end
        default: repeat ($urandom_range(0, 30)) @(negedge clk);
      endcase
    end
    do_init();
    chk("virq_final_init", VIRQ, 0);
    bus(CSR, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
